// File: rtl/my_loader_pkg.sv
// Shared types and constants for the ROM loader: FSM state encoding and byte/word widths.
package my_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CSUM_HI,
        CSUM_LO,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/my_word_assembler.sv
// Pairs a big-endian HI/LO byte sequence into a word; the HI byte is latched, the word is
// presented combinationally alongside the LO byte with a one-cycle word_valid.
module my_word_assembler
    import my_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              hi_stb,
    input  logic              lo_stb,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [BYTE_W-1:0] hi_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg <= '0;
        end else if (hi_stb) begin
            hi_reg <= byte_in;
        end
    end

    assign word       = {hi_reg, byte_in};
    assign word_valid = lo_stb;

endmodule

// File: rtl/my_rom_loader.sv
// Streams a length-prefixed program image into the instruction ROM and holds the CPU in reset
// until a complete image is present. Optional trailing checksum: define LOADER_CHECKSUM_EN.
module my_rom_loader
    import my_loader_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rom_wr_en,
    output logic [ADDR_W-1:0] rom_wr_addr,
    output logic [DATA_W-1:0] rom_wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

    loader_state_t     state_reg;
    logic              in_ready_reg;
    logic              rom_wr_en_reg;
    logic [ADDR_W-1:0] rom_wr_addr_reg;
    logic [DATA_W-1:0] rom_wr_data_reg;
    logic              cpu_hold_reg;
    logic              done_reg;
    logic              error_reg;
    logic [ADDR_W:0]   cnt_reg;
    logic [WORD_W-1:0] len_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_reg;
`endif

    logic              accept;
    logic              hi_stb;
    logic              lo_stb;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              len_too_big;
    logic              last_word;

    assign accept = in_valid & in_ready_reg;
    assign hi_stb = accept & (state_reg == LEN_HI || state_reg == DATA_HI || state_reg == CSUM_HI);
    assign lo_stb = accept & (state_reg == LEN_LO || state_reg == DATA_LO || state_reg == CSUM_LO);

    my_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (in_byte),
        .hi_stb     (hi_stb),
        .lo_stb     (lo_stb),
        .word       (word),
        .word_valid (word_valid)
    );

    assign len_too_big = {17'd0, word} > DEPTH;
    assign last_word   = ({{(32 - ADDR_W){1'b0}}, cnt_reg} + 33'd1) == {17'd0, len_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            in_ready_reg    <= 1'b0;
            rom_wr_en_reg   <= 1'b0;
            rom_wr_addr_reg <= '0;
            rom_wr_data_reg <= '0;
            cpu_hold_reg    <= 1'b1;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
            cnt_reg         <= '0;
            len_reg         <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_reg        <= '0;
`endif
        end else begin
            rom_wr_en_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_reg    <= LEN_HI;
                        in_ready_reg <= 1'b1;
                        cpu_hold_reg <= 1'b1;
                        done_reg     <= 1'b0;
                        error_reg    <= 1'b0;
                        cnt_reg      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum_reg     <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (accept) state_reg <= LEN_LO;
                end
                LEN_LO: begin
                    if (word_valid) begin
                        len_reg <= word;
                        if (len_too_big) begin
                            state_reg    <= ERR;
                            in_ready_reg <= 1'b0;
                            error_reg    <= 1'b1;
                        end else if (word == '0) begin
                            state_reg    <= DONE;
                            in_ready_reg <= 1'b0;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (accept) state_reg <= DATA_LO;
                end
                DATA_LO: begin
                    // in_ready low here means the last strobe is in flight; finish one cycle later.
                    if (!in_ready_reg) begin
                        state_reg    <= DONE;
                        done_reg     <= 1'b1;
                        cpu_hold_reg <= 1'b0;
                    end else if (word_valid) begin
                        rom_wr_en_reg   <= 1'b1;
                        rom_wr_addr_reg <= cnt_reg[ADDR_W-1:0];
                        rom_wr_data_reg <= word;
                        cnt_reg         <= cnt_reg + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum_reg        <= csum_reg + word;
                        state_reg       <= last_word ? CSUM_HI : DATA_HI;
`else
                        if (last_word) in_ready_reg <= 1'b0;
                        else           state_reg    <= DATA_HI;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM_HI: begin
                    if (accept) state_reg <= CSUM_LO;
                end
                CSUM_LO: begin
                    if (word_valid) begin
                        in_ready_reg <= 1'b0;
                        if (word == csum_reg) begin
                            state_reg    <= DONE;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= ERR;
                            error_reg <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign rom_wr_en   = rom_wr_en_reg;
    assign rom_wr_addr = rom_wr_addr_reg;
    assign rom_wr_data = rom_wr_data_reg;
    assign cpu_hold    = cpu_hold_reg;
    assign done        = done_reg;
    assign error       = error_reg;

endmodule

// File: tb/tb_my_rom_loader.sv
// Self-checking bench for my_rom_loader: frame table plus hand sequences, ROM writes scoreboarded.
module tb_my_rom_loader;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              rom_wr_en;
    logic [ADDR_W-1:0] rom_wr_addr;
    logic [DATA_W-1:0] rom_wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    my_rom_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rom_wr_en   (rom_wr_en),
        .rom_wr_addr (rom_wr_addr),
        .rom_wr_data (rom_wr_data),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nb;
        logic [79:0] bytes;
        bit          gap;
        bit          exp_done;
        bit          exp_error;
        int          exp_writes;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [30:0] exp_q[$];
    int cyc = 0, last_wr = 0, prev_wr = 0, done_rise = 0, nwr = 0;
    logic done_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (done && !done_q) done_rise = cyc;
        done_q = done;
        if (rom_wr_en) begin
            prev_wr = last_wr;
            last_wr = cyc;
            nwr++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'({rom_wr_addr, rom_wr_data}), 64'h7fffffffffffffff);
            end else begin
                logic [30:0] e;
                e = exp_q.pop_front();
                chk("rom_write", 64'({rom_wr_addr, rom_wr_data}), 64'(e));
            end
        end
    end

    function automatic logic [7:0] byte_at(input logic [79:0] b, input int i);
        return b[79 - 8*i -: 8];
    endfunction

    task automatic push_writes(input logic [79:0] b, input int nb);
        int n;
        n = int'({byte_at(b, 0), byte_at(b, 1)});
        if (n <= (1 << ADDR_W)) begin
            for (int i = 0; i < n && (3 + 2*i) < nb; i++)
                exp_q.push_back({15'(i), byte_at(b, 2 + 2*i), byte_at(b, 3 + 2*i)});
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        logic rdy;
        bit ok;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_byte  = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
        if (!ok) chk("byte_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_finish();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (done || error) seen = 1'b1;
        end
        if (!seen) chk("finish_timeout", 64'(seen), 64'd1);
    endtask

    task automatic check_reset_state(input string name);
        chk(name, 64'({in_ready, rom_wr_en, rom_wr_addr, rom_wr_data, cpu_hold, done, error}),
            64'({1'b0, 1'b0, 15'd0, 16'd0, 1'b1, 1'b0, 1'b0}));
    endtask

    vec_t vecs[6];
    int nvec;

    initial begin
`ifdef LOADER_CHECKSUM_EN
        vecs[0] = '{8, 80'h0002_1234_ABCD_BE01_0000, 1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{8, 80'h0002_1234_ABCD_BE01_0000, 1'b1, 1'b1, 1'b0, 2};
        vecs[2] = '{2, 80'h8001_0000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{2, 80'h0000_0000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 0};
        vecs[4] = '{6, 80'h0001_0005_0005_0000_0000, 1'b0, 1'b1, 1'b0, 1};
        vecs[5] = '{6, 80'h0001_0005_0006_0000_0000, 1'b0, 1'b0, 1'b1, 1};
        nvec = 6;
`else
        vecs[0] = '{6, 80'h0002_1234_ABCD_0000_0000, 1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{6, 80'h0002_1234_ABCD_0000_0000, 1'b1, 1'b1, 1'b0, 2};
        vecs[2] = '{2, 80'h8001_0000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{2, 80'h0000_0000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 0};
        vecs[4] = '{8, 80'h0003_0001_0002_0003_0000, 1'b1, 1'b1, 1'b0, 3};
        nvec = 5;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_state");
        #1 reset = 1'b0;

        for (int v = 0; v < nvec; v++) begin
            int nwr0;
            nwr0 = nwr;
            pulse_start();
            push_writes(vecs[v].bytes, vecs[v].nb);
            for (int i = 0; i < vecs[v].nb; i++)
                send_byte(byte_at(vecs[v].bytes, i), vecs[v].gap);
            wait_finish();
            @(negedge clk);
            chk($sformatf("v%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
            chk($sformatf("v%0d_error", v), 64'(error), 64'(vecs[v].exp_error));
            chk($sformatf("v%0d_cpu_hold", v), 64'(cpu_hold), 64'(!vecs[v].exp_done));
            chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'd0);
            chk($sformatf("v%0d_writes", v), 64'(nwr - nwr0), 64'(vecs[v].exp_writes));
            chk($sformatf("v%0d_queue_left", v), 64'(exp_q.size()), 64'd0);
`ifndef LOADER_CHECKSUM_EN
            if (v == 0) begin
                chk("done_after_strobe", 64'(done_rise - last_wr), 64'd1);
                chk("strobe_spacing", 64'(last_wr - prev_wr), 64'd2);
            end
`endif
        end

        // N == DEPTH is accepted: loader moves on to data instead of ERR.
        pulse_start();
        send_byte(8'h80, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        chk("depth_len_error", 64'(error), 64'd0);
        chk("depth_len_ready", 64'({in_ready, cpu_hold}), 64'({1'b1, 1'b1}));
        #2 reset = 1'b1;
        @(negedge clk);
        check_reset_state("reset_after_depth");
        #1 reset = 1'b0;

        // Reset mid-load, with an ignored start while busy, then reload from address 0.
        pulse_start();
        exp_q.push_back({15'd0, 16'h1111});
        exp_q.push_back({15'd1, 16'h2222});
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        pulse_start();
        send_byte(8'h22, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("busy_start_ignored", 64'({in_ready, done, error}), 64'({1'b1, 1'b0, 1'b0}));
        #2 reset = 1'b1;
        @(negedge clk);
        check_reset_state("reset_mid_load");
        chk("mid_load_queue", 64'(exp_q.size()), 64'd0);
        #1 reset = 1'b0;
        pulse_start();
        exp_q.push_back({15'd0, 16'h0777});
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h77, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h07, 1'b0);
        send_byte(8'h77, 1'b0);
`endif
        wait_finish();
        @(negedge clk);
        chk("reload_done", 64'({done, error, cpu_hold}), 64'({1'b1, 1'b0, 1'b0}));
        chk("reload_queue", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
